fp4_fft_input_loader: RTL
=========================

Name: fp4_fft_input_loader

Overview:
Write-side controller for the FP4 FFT ping-pong sample memory. It accepts a stream of packed complex FP4 samples over a valid/ready handshake and writes each frame into the filling bank, bit-reversed by default. When a frame is full and the FFT core is idle, it toggles bank_sel and pulses frame_start. It drives the memory write port and bank select, and handshakes with the FFT core's done pulse.

Parameters:
N, 32, points per frame (power of two)
ADDR_W, 5, log2(N); memory address width
DATA_W, 8, sample width; [3:0] real FP4, [7:4] imag FP4
BITREV_EN, 1, 1 = write address is bit-reverse of sample index; 0 = natural order

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
s_valid  in  1  upstream sample valid
s_ready  out  1  loader can accept a sample
s_data  in  DATA_W  upstream sample
wr_en_1  out  1  memory write enable
wr_addr_1  out  ADDR_W  memory write address
wr_data_1  out  DATA_W  memory write data
bank_sel  out  1  memory bank select; loader writes bank !bank_sel
frame_start  out  1  one-cycle pulse: new frame is readable in bank bank_sel
proc_done  in  1  one-cycle pulse from FFT core: current frame finished
proc_busy  out  1  core owns the processing bank
err_done  out  1  sticky: proc_done seen while proc_busy=0

Behaviour:
- Reset (rst=0, async) forces: state=FILL, idx=0, bank_sel=0, proc_busy=0, frame_start=0, err_done=0. s_ready reads 1 after reset release. The first frame goes to bank1.
- States:
  - FILL: s_ready=1.
  - FULL: s_ready=0; waits for the core to be idle.
- Accept = s_valid & s_ready.
- The write path is combinational, with zero latency:
  - wr_en_1 = accept
  - wr_data_1 = s_data
  - wr_addr_1 = BITREV_EN ? bitrev(idx) : idx
  - The memory captures the write on the same clk edge as the accept.
- FILL: on accept, idx increments. On accept with idx==N-1: idx wraps to 0 and the block goes to FULL. It does not swap in the same cycle, even if the core is idle.
- FULL: swap condition = !proc_busy | proc_done. On the swap edge:
  - bank_sel toggles.
  - frame_start=1 for exactly one cycle, registered, aligned with the new bank_sel value.
  - proc_busy is set to 1.
  - state returns to FILL.
- proc_busy:
  - Set on swap.
  - Cleared on proc_done when no swap occurs in the same cycle.
  - proc_done and swap in the same cycle: the swap wins, so proc_busy stays 1 (back-to-back frames, no idle cycle).
- Throughput:
  - With the core idle, there is a one-cycle bubble per frame (the FULL cycle).
  - With the core busy, s_ready stays low until proc_done.
  - The loader never writes the bank the core is reading.
- A proc_done while proc_busy=0 sets err_done (sticky until reset) and is otherwise ignored.
- A gapped s_valid has no effect on idx. s_data is don't-care when not accepted.
- Reset mid-fill discards the partial frame; memory contents are not cleared by this block.
- bitrev reverses all ADDR_W bits, e.g. idx 1 -> 16, idx 3 -> 24 for N=32.

Decomposition:
- Shared package fp4_fft_pkg: N, ADDR_W, DATA_W, FP4 field slices (real [3:0], imag [7:4]), and the state encoding (FILL=0, FULL=1).
- One natural sub-module, bit_reverse (parameterised width, combinational), reused later by the read-side unloader.

Test Plan:
1. Reset, then 32 accepts with s_data=i, core idle -> wr_addr_1 sequence 0,16,8,24,...,31; all writes land in bank1; one FULL cycle; then bank_sel=1, frame_start one cycle, proc_busy=1.
2. Second frame streamed with no proc_done -> 32 writes to bank0; s_ready=0 and bank_sel held at 1 indefinitely. proc_done pulse -> on that edge bank_sel=0, frame_start=1, proc_busy stays 1.
3. proc_done asserted in the FULL cycle, i.e. the cycle after the 32nd accept -> the swap occurs that edge, proc_busy never drops, err_done=0.
4. s_valid toggling randomly (~50%) across a frame -> exactly 32 writes, addresses match the bit-reversed order with no skips or repeats, frame_start after the 32nd.
5. rst pulsed low asynchronously after 10 accepts -> outputs return to reset values immediately; the next frame restarts at idx 0 in bank1.
6. BITREV_EN=0 variant, plus a proc_done pulse before any frame -> addresses 0..31 in order; err_done=1 and stays set.

Source files
------------

// File: rtl/fp4_fft_pkg.sv
// Shared definitions for the FP4 FFT sample path: frame geometry, FP4 field
// positions inside a packed complex sample, and the loader state encoding.
package fp4_fft_pkg;

  localparam int N      = 32;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;

  // Packed complex sample: real FP4 in the low nibble, imaginary FP4 above it.
  localparam int FP4_RE_LSB = 0;
  localparam int FP4_RE_MSB = 3;
  localparam int FP4_IM_LSB = 4;
  localparam int FP4_IM_MSB = 7;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } loader_state_t;

  function automatic logic [3:0] fp4_re(input logic [DATA_W-1:0] sample);
    return sample[FP4_RE_MSB:FP4_RE_LSB];
  endfunction

  function automatic logic [3:0] fp4_im(input logic [DATA_W-1:0] sample);
    return sample[FP4_IM_MSB:FP4_IM_LSB];
  endfunction

endpackage

// File: rtl/fp4_fft_input_loader_bit_reverse.sv
// Combinational bit reversal of a W-bit index; shared by the FFT loader and
// the read-side unloader.
module bit_reverse #(
  parameter int W = 5
) (
  input  logic [W-1:0] in_bits,
  output logic [W-1:0] out_bits
);

  for (genvar gi = 0; gi < W; gi++) begin : g_rev
    assign out_bits[gi] = in_bits[W-1-gi];
  end

endmodule

// File: rtl/fp4_fft_input_loader.sv
// Write-side controller for the FP4 FFT ping-pong memory: fills the idle bank
// from a valid/ready stream, then hands the frame to the FFT core.
module fp4_fft_input_loader #(
  parameter int N         = fp4_fft_pkg::N,
  parameter int ADDR_W    = fp4_fft_pkg::ADDR_W,
  parameter int DATA_W    = fp4_fft_pkg::DATA_W,
  parameter bit BITREV_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              wr_en_1,
  output logic [ADDR_W-1:0] wr_addr_1,
  output logic [DATA_W-1:0] wr_data_1,
  output logic              bank_sel,
  output logic              frame_start,
  input  logic              proc_done,
  output logic              proc_busy,
  output logic              err_done
);

  import fp4_fft_pkg::*;

  loader_state_t     state_reg, state_next;
  logic [ADDR_W-1:0] idx_reg, idx_next;
  logic              bank_sel_reg, bank_sel_next;
  logic              frame_start_reg, frame_start_next;
  logic              proc_busy_reg, proc_busy_next;
  logic              err_done_reg, err_done_next;
  logic              accept;
  logic              swap;
  logic [ADDR_W-1:0] idx_rev;

  bit_reverse #(.W(ADDR_W)) u_bit_reverse (
    .in_bits  (idx_reg),
    .out_bits (idx_rev)
  );

  assign s_ready = (state_reg == ST_FILL);
  assign accept  = s_valid & s_ready;
  // A finishing core may take the next frame in the same cycle it reports done.
  assign swap    = (state_reg == ST_FULL) & (~proc_busy_reg | proc_done);

  assign wr_en_1   = accept;
  assign wr_data_1 = s_data;
  assign wr_addr_1 = BITREV_EN ? idx_rev : idx_reg;

  assign bank_sel    = bank_sel_reg;
  assign frame_start = frame_start_reg;
  assign proc_busy   = proc_busy_reg;
  assign err_done    = err_done_reg;

  always_comb begin
    state_next       = state_reg;
    idx_next         = idx_reg;
    bank_sel_next    = bank_sel_reg;
    frame_start_next = 1'b0;
    proc_busy_next   = proc_busy_reg;
    err_done_next    = err_done_reg | (proc_done & ~proc_busy_reg);

    if (proc_done) begin
      proc_busy_next = 1'b0;
    end

    case (state_reg)
      ST_FILL: begin
        if (accept) begin
          if (idx_reg == ADDR_W'(N - 1)) begin
            idx_next   = '0;
            state_next = ST_FULL;
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end
      end
      ST_FULL: begin
        if (swap) begin
          bank_sel_next    = ~bank_sel_reg;
          frame_start_next = 1'b1;
          proc_busy_next   = 1'b1;
          state_next       = ST_FILL;
        end
      end
      default: state_next = ST_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= ST_FILL;
      idx_reg         <= '0;
      bank_sel_reg    <= 1'b0;
      frame_start_reg <= 1'b0;
      proc_busy_reg   <= 1'b0;
      err_done_reg    <= 1'b0;
    end else begin
      state_reg       <= state_next;
      idx_reg         <= idx_next;
      bank_sel_reg    <= bank_sel_next;
      frame_start_reg <= frame_start_next;
      proc_busy_reg   <= proc_busy_next;
      err_done_reg    <= err_done_next;
    end
  end

endmodule
